// File: rtl/feedback_settle_engine_pkg.sv
// Shared types and helpers for the feedback settling engine.
package feedback_settle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int iter_width(input int max_iter);
        return $clog2(max_iter + 1);
    endfunction

endpackage

// File: rtl/feedback_settle_engine_if.sv
// Request/result handshake bundle for feedback_settle_engine.
// Optional i_seed signal exists only when SETTLE_SEED_EN is defined.
interface feedback_settle_engine_if #(
    parameter int WIDTH    = 16,
    parameter int MAX_ITER = 8
);
    localparam int ITER_W = feedback_settle_pkg::iter_width(MAX_ITER);

    logic              i_valid;
    logic              o_ready;
    logic [WIDTH-1:0]  i_data;
    logic              i_control;
`ifdef SETTLE_SEED_EN
    logic [WIDTH-1:0]  i_seed;
`endif
    logic              o_valid;
    logic              i_ready;
    logic [WIDTH-1:0]  o_result;
    logic              o_converged;
    logic [ITER_W-1:0] o_iter_count;

    modport slave (
        input  i_valid, i_data, i_control,
`ifdef SETTLE_SEED_EN
        input  i_seed,
`endif
        input  i_ready,
        output o_ready, o_valid, o_result, o_converged, o_iter_count
    );

    modport master (
        output i_valid, i_data, i_control,
`ifdef SETTLE_SEED_EN
        output i_seed,
`endif
        output i_ready,
        input  o_ready, o_valid, o_result, o_converged, o_iter_count
    );

endinterface

// File: rtl/feedback_settle_engine_step.sv
// One combinational evaluation of the add/XOR feedback network.
module feedback_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] t2_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             control_i,
    output logic [WIDTH-1:0] t1_o,
    output logic [WIDTH-1:0] t2n_o,
    output logic             eq_o
);

    assign t1_o  = t2_i + data_i;
    assign t2n_o = t1_o ^ {WIDTH{control_i}};
    assign eq_o  = (t2n_o == t2_i);

endmodule

// File: rtl/feedback_settle_engine.sv
// Iterates the feedback network one step per clock until a fixed point or MAX_ITER.
// Build option: SETTLE_SEED_EN seeds temp2 from i_seed instead of zero.
module feedback_settle_engine
    import feedback_settle_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MAX_ITER = 8
) (
    input logic                     i_clk,
    input logic                     i_rst_n,
    feedback_settle_engine_if.slave bus
);

    localparam int ITER_W = iter_width(MAX_ITER);
    localparam logic [ITER_W-1:0] LAST_CNT = ITER_W'(MAX_ITER);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              ctl_q, ctl_d;
    logic [WIDTH-1:0]  t2_q, t2_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              conv_q, conv_d;
    logic [ITER_W-1:0] iter_q, iter_d;

    logic [WIDTH-1:0]  t1_s, t2n_s, seed_s;
    logic              eq_s;
    logic [ITER_W-1:0] cnt_inc_s;

`ifdef SETTLE_SEED_EN
    assign seed_s = bus.i_seed;
`else
    assign seed_s = {WIDTH{1'b0}};
`endif

    assign cnt_inc_s = cnt_q + {{(ITER_W-1){1'b0}}, 1'b1};

    feedback_step #(.WIDTH(WIDTH)) u_step (
        .t2_i      (t2_q),
        .data_i    (data_q),
        .control_i (ctl_q),
        .t1_o      (t1_s),
        .t2n_o     (t2n_s),
        .eq_o      (eq_s)
    );

    // Next-state and datapath update for the IDLE/ITER/DONE controller.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        ctl_d    = ctl_q;
        t2_d     = t2_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        conv_d   = conv_q;
        iter_d   = iter_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    data_d  = bus.i_data;
                    ctl_d   = bus.i_control;
                    t2_d    = seed_s;
                    cnt_d   = {ITER_W{1'b0}};
                    state_d = ITER;
                end else begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                t2_d  = t2n_s;
                cnt_d = cnt_inc_s;
                // Convergence wins when it coincides with the iteration limit.
                if (eq_s) begin
                    state_d  = DONE;
                    conv_d   = 1'b1;
                    result_d = t1_s & t2n_s;
                    iter_d   = cnt_inc_s;
                end else if (cnt_inc_s == LAST_CNT) begin
                    state_d  = DONE;
                    conv_d   = 1'b0;
                    result_d = t1_s & t2n_s;
                    iter_d   = cnt_inc_s;
                end else begin
                    state_d = ITER;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            data_q   <= {WIDTH{1'b0}};
            ctl_q    <= 1'b0;
            t2_q     <= {WIDTH{1'b0}};
            cnt_q    <= {ITER_W{1'b0}};
            result_q <= {WIDTH{1'b0}};
            conv_q   <= 1'b0;
            iter_q   <= {ITER_W{1'b0}};
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            ctl_q    <= ctl_d;
            t2_q     <= t2_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            conv_q   <= conv_d;
            iter_q   <= iter_d;
        end
    end

    assign bus.o_ready      = (state_q == IDLE);
    assign bus.o_valid      = (state_q == DONE);
    assign bus.o_result     = result_q;
    assign bus.o_converged  = conv_q;
    assign bus.o_iter_count = iter_q;

endmodule

// File: tb/tb_feedback_settle_engine.sv
// Randomized self-checking bench for feedback_settle_engine against a loop-level reference.
module tb_feedback_settle_engine;
    import feedback_settle_pkg::*;

    localparam int WIDTH    = 16;
    localparam int MAX_ITER = 8;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    feedback_settle_engine_if #(.WIDTH(WIDTH), .MAX_ITER(MAX_ITER)) bus ();

    feedback_settle_engine #(.WIDTH(WIDTH), .MAX_ITER(MAX_ITER)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: iterate temp1 = temp2 + data, temp2 = temp1 ^ mask until fixed point or limit.
    task automatic ref_settle(input logic [15:0] seed, input logic [15:0] data, input logic ctl,
                              output logic [15:0] res, output logic conv, output int n);
        logic [15:0] t2, t1, t2n;
        t2   = seed;
        conv = 1'b0;
        res  = 16'h0000;
        n    = 0;
        for (int k = 1; k <= MAX_ITER; k++) begin
            t1  = t2 + data;
            t2n = t1 ^ (ctl ? 16'hFFFF : 16'h0000);
            n   = k;
            res = t1 & t2n;
            if (t2n == t2) begin
                conv = 1'b1;
                break;
            end
            t2 = t2n;
        end
    endtask

    task automatic run_txn(input logic [15:0] data, input logic ctl, input logic [15:0] seed_in,
                           input int hold, input bit scramble);
        logic [15:0] er;
        logic        ec;
        int          en;
        int          cyc;
        bit          seen;
        logic [15:0] seed;
`ifdef SETTLE_SEED_EN
        seed = seed_in;
`else
        seed = 16'h0000;
        if (seed_in != 16'h0000) seed = 16'h0000;
`endif
        ref_settle(seed, data, ctl, er, ec, en);

        cyc = 0;
        while (!bus.o_ready && cyc < 20) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("ready_before_req", bus.o_ready, 32'd1);

        bus.i_valid   = 1'b1;
        bus.i_data    = data;
        bus.i_control = ctl;
`ifdef SETTLE_SEED_EN
        bus.i_seed    = seed;
`endif
        bus.i_ready   = (hold == 0);
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        chk("busy_not_ready", bus.o_ready, 32'd0);

        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < MAX_ITER + 4) begin
            if (scramble) begin
                bus.i_data    = 16'($urandom);
                bus.i_control = 1'($urandom);
            end
            @(negedge i_clk);
            cyc++;
            seen = bus.o_valid;
        end
        chk("latency", 32'(cyc), 32'(en));
        chk("result", {16'h0000, bus.o_result}, {16'h0000, er});
        chk("converged", {31'd0, bus.o_converged}, {31'd0, ec});
        chk("iter_count", 32'(bus.o_iter_count), 32'(en));
        chk("done_not_ready", bus.o_ready, 32'd0);

        for (int h = 0; h < hold; h++) begin
            @(negedge i_clk);
            chk("hold_valid", bus.o_valid, 32'd1);
            chk("hold_result", {16'h0000, bus.o_result}, {16'h0000, er});
            chk("hold_count", 32'(bus.o_iter_count), 32'(en));
            chk("hold_not_ready", bus.o_ready, 32'd0);
        end
        bus.i_ready = 1'b1;
        @(negedge i_clk);
        chk("valid_drop", bus.o_valid, 32'd0);
        chk("ready_after", bus.o_ready, 32'd1);
        chk("result_kept", {16'h0000, bus.o_result}, {16'h0000, er});
        bus.i_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [15:0] s;
        int          sel;

        bus.i_valid   = 1'b0;
        bus.i_data    = 16'h0000;
        bus.i_control = 1'b0;
        bus.i_ready   = 1'b0;
`ifdef SETTLE_SEED_EN
        bus.i_seed    = 16'h0000;
`endif
        repeat (3) @(negedge i_clk);
        chk("rst_valid", bus.o_valid, 32'd0);
        chk("rst_ready", bus.o_ready, 32'd1);
        chk("rst_result", {16'h0000, bus.o_result}, 32'd0);
        chk("rst_conv", {31'd0, bus.o_converged}, 32'd0);
        chk("rst_count", 32'(bus.o_iter_count), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        run_txn(16'h0000, 1'b0, 16'h0000, 0, 1'b0);
        run_txn(16'h0003, 1'b0, 16'h0000, 0, 1'b0);
        run_txn(16'h0001, 1'b1, 16'h0000, 2, 1'b0);
        run_txn(16'h0003, 1'b0, 16'h0000, 5, 1'b1);
        run_txn(16'hFFFF, 1'b1, 16'h0000, 1, 1'b1);
`ifdef SETTLE_SEED_EN
        run_txn(16'h0001, 1'b1, 16'h7FFF, 0, 1'b0);
`endif

        // Reset in the middle of iterating the data=3 case.
        bus.i_valid   = 1'b1;
        bus.i_data    = 16'h0003;
        bus.i_control = 1'b0;
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("mid_busy", bus.o_ready, 32'd0);
        #1 i_rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.o_valid, 32'd0);
        chk("arst_ready", bus.o_ready, 32'd1);
        chk("arst_result", {16'h0000, bus.o_result}, 32'd0);
        chk("arst_conv", {31'd0, bus.o_converged}, 32'd0);
        chk("arst_count", 32'(bus.o_iter_count), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        run_txn(16'h0003, 1'b0, 16'h0000, 0, 1'b0);

        for (int r = 0; r < 24; r++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       d = 16'h0000;
                1:       d = 16'hFFFF;
                2:       d = 16'($urandom_range(1, 15));
                default: d = 16'($urandom);
            endcase
            s = 16'($urandom);
            run_txn(d, 1'($urandom), s, $urandom_range(0, 3), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
